// File: rtl/arbitro_somador_pkg.sv
// Shared dual-rail (NCL) codes, controller state encoding and the
// encode/decode/completion helpers used by the arbiter and its synchronizer.
package arbitro_somador_pkg;

    // Pair layout is {true, false}; 2'b11 is never a legal code.
    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_DATA0 = 2'b01;
    localparam logic [1:0] DR_DATA1 = 2'b10;

    // Stage return bundle: {ack_out, cout[1:0], soma[7:0]}
    localparam int STAGE_RET_W = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_DATA,
        S_WAIT_DATA,
        S_ISSUE_NULL,
        S_WAIT_NULL,
        S_RESPOND
    } state_t;

    function automatic logic [1:0] dr_encode_bit(input logic b);
        return b ? DR_DATA1 : DR_DATA0;
    endfunction

    function automatic logic [7:0] dr_encode4(input logic [3:0] v);
        logic [7:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            d[2*i +: 2] = dr_encode_bit(v[i]);
        end
        return d;
    endfunction

    function automatic logic [3:0] dr_decode4(input logic [7:0] d);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[i] = d[2*i+1];
        end
        return v;
    endfunction

    // True only when every pair carries a legal DATA code.
    function automatic logic dr_all_data(input logic [9:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (d[2*i +: 2] == DR_NULL || d[2*i +: 2] == 2'b11) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic dr_all_null(input logic [9:0] d);
        return d == '0;
    endfunction

endpackage

// File: rtl/arbitro_somador_if.sv
// Dual-rail link between the arbiter (master) and the asynchronous adder stage (slave).
interface arbitro_somador_if;
    logic [7:0] st_a;
    logic [7:0] st_b;
    logic [1:0] st_cin;
    logic       st_ack_in;
    logic       st_ack_out;
    logic [7:0] st_soma;
    logic [1:0] st_cout;

    modport master (
        output st_a, st_b, st_cin, st_ack_in,
        input  st_ack_out, st_soma, st_cout
    );

    modport slave (
        input  st_a, st_b, st_cin, st_ack_in,
        output st_ack_out, st_soma, st_cout
    );
endinterface

// File: rtl/ncl_sincronizador.sv
// Flop chain that brings the stage's asynchronous return signals into clk.
// Every tap is exported so the controller can demand agreement across the chain.
module ncl_sincronizador #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             d,
    output logic [STAGES-1:0][WIDTH-1:0] taps
);

    logic [STAGES-1:0][WIDTH-1:0] chain_reg;
    logic [STAGES-1:0][WIDTH-1:0] chain_next;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_next[gi] = d;
            end else begin : g_rest
                assign chain_next[gi] = chain_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= chain_next;
        end
    end

    assign taps = chain_reg;

endmodule

// File: rtl/arbitro_somador.sv
// Two-requester round-robin front end for a 4-bit NCL adder stage: issues a
// DATA wavefront, waits for completion, returns the stage to NULL, then responds.
module arbitro_somador
    import arbitro_somador_pkg::*;
#(
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req0_cin,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic       req1_cin,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_sum,
    output logic       rsp_cout,
    output logic       rsp_err,
    arbitro_somador_if.master st
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_reg, state_next;
    logic [3:0]       op_a_reg, op_a_next;
    logic [3:0]       op_b_reg, op_b_next;
    logic             op_cin_reg, op_cin_next;
    logic             prio_reg, prio_next;
    logic             rsp_id_reg, rsp_id_next;
    logic [3:0]       rsp_sum_reg, rsp_sum_next;
    logic             rsp_cout_reg, rsp_cout_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [SYNC_STAGES-1:0][STAGE_RET_W-1:0] sync_taps;
    logic [SYNC_STAGES-1:0]                  tap_data_ok;
    logic [STAGE_RET_W-1:0]                  last_ret;
    logic                                    data_ok;
    logic                                    null_ok;
    logic                                    grant_fire;
    logic                                    grant_id;
    logic                                    timed_out;

    ncl_sincronizador #(
        .WIDTH (STAGE_RET_W),
        .STAGES(SYNC_STAGES)
    ) u_sincronizador (
        .clk  (clk),
        .reset(reset),
        .d    ({st.st_ack_out, st.st_cout, st.st_soma}),
        .taps (sync_taps)
    );

    // A DATA wavefront is accepted only once every synchronizer tap agrees,
    // i.e. SYNC_STAGES consecutive samples show ack plus complete, legal pairs.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_tap
            assign tap_data_ok[gi] = sync_taps[gi][STAGE_RET_W-1]
                                     && dr_all_data(sync_taps[gi][9:0]);
        end
    endgenerate

    assign last_ret  = sync_taps[SYNC_STAGES-1];
    assign data_ok   = &tap_data_ok;
    assign null_ok   = !last_ret[STAGE_RET_W-1] && dr_all_null(last_ret[9:0]);
    assign timed_out = (cnt_reg == CNT_W'(TIMEOUT));

    assign grant_id   = (req0_valid && req1_valid) ? prio_reg : req1_valid;
    assign grant_fire = (state_reg == S_IDLE) && (req0_valid || req1_valid) && !rsp_valid;

    always_comb begin
        state_next    = state_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        op_cin_next   = op_cin_reg;
        prio_next     = prio_reg;
        rsp_id_next   = rsp_id_reg;
        rsp_sum_next  = rsp_sum_reg;
        rsp_cout_next = rsp_cout_reg;
        rsp_err_next  = rsp_err_reg;
        cnt_next      = '0;

        case (state_reg)
            S_IDLE: begin
                if (grant_fire) begin
                    op_a_next    = grant_id ? req1_a   : req0_a;
                    op_b_next    = grant_id ? req1_b   : req0_b;
                    op_cin_next  = grant_id ? req1_cin : req0_cin;
                    rsp_id_next  = grant_id;
                    rsp_err_next = 1'b0;
                    prio_next    = ~grant_id;
                    state_next   = S_ISSUE_DATA;
                end
            end
            S_ISSUE_DATA: state_next = S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (data_ok) begin
                    rsp_sum_next  = dr_decode4(last_ret[7:0]);
                    rsp_cout_next = last_ret[9];
                    state_next    = S_ISSUE_NULL;
                end else if (timed_out) begin
                    rsp_sum_next  = '0;
                    rsp_cout_next = 1'b0;
                    rsp_err_next  = 1'b1;
                    state_next    = S_ISSUE_NULL;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_ISSUE_NULL: state_next = S_WAIT_NULL;
            S_WAIT_NULL: begin
                if (null_ok) begin
                    state_next = S_RESPOND;
                end else if (timed_out) begin
                    rsp_err_next = 1'b1;
                    state_next   = S_RESPOND;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RESPOND: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_cin_reg   <= 1'b0;
            prio_reg     <= 1'b0;
            rsp_id_reg   <= 1'b0;
            rsp_sum_reg  <= '0;
            rsp_cout_reg <= 1'b0;
            rsp_err_reg  <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            op_cin_reg   <= op_cin_next;
            prio_reg     <= prio_next;
            rsp_id_reg   <= rsp_id_next;
            rsp_sum_reg  <= rsp_sum_next;
            rsp_cout_reg <= rsp_cout_next;
            rsp_err_reg  <= rsp_err_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Stage inputs come straight from registered state/operands, so they
    // switch as a whole wavefront on a single edge.
    always_comb begin
        st.st_a      = {4{DR_NULL}};
        st.st_b      = {4{DR_NULL}};
        st.st_cin    = DR_NULL;
        st.st_ack_in = 1'b0;
        if (state_reg == S_ISSUE_DATA || state_reg == S_WAIT_DATA) begin
            st.st_a   = dr_encode4(op_a_reg);
            st.st_b   = dr_encode4(op_b_reg);
            st.st_cin = dr_encode_bit(op_cin_reg);
        end
        if (state_reg == S_ISSUE_NULL || state_reg == S_WAIT_NULL) begin
            st.st_ack_in = 1'b1;
        end
    end

    assign req0_ready = reset && grant_fire && !grant_id;
    assign req1_ready = reset && grant_fire &&  grant_id;
    assign rsp_valid  = (state_reg == S_RESPOND);
    assign rsp_id     = rsp_id_reg;
    assign rsp_sum    = rsp_sum_reg;
    assign rsp_cout   = rsp_cout_reg;
    assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_arbitro_somador.sv
// Randomized self-checking bench: ideal/dead NCL stage model plus an
// arithmetic and round-robin reference model of the arbiter.
module tb_arbitro_somador;

    localparam int TIMEOUT = 255;
    localparam int SYNC    = 2;
    localparam int MIN_LAT = 3 + 2 * SYNC;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_cin = 1'b0, req1_cin = 1'b0;
    logic       req0_ready, req1_ready;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_id;
    logic [3:0] rsp_sum;
    logic       rsp_cout;
    logic       rsp_err;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int pref      = 0;
    bit stage_dead = 1'b0;

    arbitro_somador_if st_if ();

    arbitro_somador #(
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cin  (req0_cin),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cin  (req1_cin),
        .req1_ready(req1_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .st        (st_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] rail(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] enc4(input logic [3:0] v);
        return {rail(v[3]), rail(v[2]), rail(v[1]), rail(v[0])};
    endfunction

    function automatic int true_val(input logic [7:0] v);
        return (v[7] ? 8 : 0) + (v[5] ? 4 : 0) + (v[3] ? 2 : 0) + (v[1] ? 1 : 0);
    endfunction

    function automatic bit complete(input logic [17:0] v);
        for (int i = 0; i < 9; i++) begin
            if (v[2*i +: 2] != 2'b01 && v[2*i +: 2] != 2'b10) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Instant stage: DATA in -> sum out with ack high; anything else -> NULL, ack low.
    int stage_sum;
    always_comb begin
        stage_sum = true_val(st_if.st_a) + true_val(st_if.st_b) + (st_if.st_cin == 2'b10 ? 1 : 0);
        st_if.st_ack_out = 1'b0;
        st_if.st_soma    = '0;
        st_if.st_cout    = '0;
        if (!stage_dead && complete({st_if.st_cin, st_if.st_b, st_if.st_a})) begin
            st_if.st_ack_out = 1'b1;
            st_if.st_soma    = enc4(4'(stage_sum % 16));
            st_if.st_cout    = rail(stage_sum >= 16);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: observed %0h required %0h", tag, got, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        pref  = 0;
    endtask

    // One full operation; entered just after a posedge with requests driven.
    task automatic do_op(input int max_wait, input int hold, input bit drop, input bit exp_err);
        int         gexp, lat, s;
        bit         found;
        logic [3:0] ea, eb, esum;
        logic       ec, ecout;
        logic [9:0] exp_vec;
        gexp  = (req0_valid && req1_valid) ? pref : (req1_valid ? 1 : 0);
        found = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                found = 1'b1;
                break;
            end
        end
        check_val("grant_seen", found, 1);
        if (!found) return;
        check_val("grant", {req0_ready, req1_ready}, gexp ? 2'b01 : 2'b10);
        ea   = gexp ? req1_a : req0_a;
        eb   = gexp ? req1_b : req0_b;
        ec   = gexp ? req1_cin : req0_cin;
        s    = int'(ea) + int'(eb) + int'(ec);
        pref = 1 - gexp;
        @(posedge clk);
        #1;
        if (drop) begin
            if (gexp == 1) req1_valid = 1'b0;
            else           req0_valid = 1'b0;
        end
        lat = 1;
        @(negedge clk);
        check_val("st_data", {st_if.st_cin, st_if.st_b, st_if.st_a}, {rail(ec), enc4(eb), enc4(ea)});
        while (!rsp_valid && lat < 2 * TIMEOUT + 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("rsp_seen", rsp_valid, 1);
        if (!rsp_valid) return;
        esum    = exp_err ? 4'd0 : 4'(s % 16);
        ecout   = exp_err ? 1'b0 : (s >= 16);
        exp_vec = {1'b1, gexp[0], esum, ecout, exp_err, 2'b00};
        check_val("rsp", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err, req0_ready, req1_ready}, exp_vec);
        if (exp_err) check_val("latency_timeout", (lat >= TIMEOUT && lat <= TIMEOUT + 8), 1);
        else         check_val("latency", lat, MIN_LAT);
        $display("op id=%0d a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d err=%0d lat=%0d",
                 gexp, ea, eb, ec, rsp_sum, rsp_cout, rsp_err, lat);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("rsp_hold", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err, req0_ready, req1_ready}, exp_vec);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset values, with both requests pending so ready gating is exercised.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err}, 0);
        check_val("rst_stage", {st_if.st_ack_in, st_if.st_cin, st_if.st_b, st_if.st_a}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        pref  = 0;

        // Directed operations.
        req0_a = 4'd3; req0_b = 4'd5; req0_cin = 1'b0; req0_valid = 1'b1;
        do_op(20, 0, 1'b1, 1'b0);
        req1_a = 4'd15; req1_b = 4'd1; req1_cin = 1'b1; req1_valid = 1'b1;
        do_op(20, 0, 1'b1, 1'b0);

        // Continuous contention from reset: grants must alternate.
        apply_reset();
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_cin = 1'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_cin = 1'($urandom);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) do_op(20, 0, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 20; i++) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            if (!req0_valid && !req1_valid) req0_valid = 1'b1;
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_cin = 1'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_cin = 1'($urandom);
            do_op(20, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Long stall: outputs frozen, no grant; the pending request wins right after release.
        req0_a = 4'd9;  req0_b = 4'd9; req0_cin = 1'b1;
        req1_a = 4'd2;  req1_b = 4'd4; req1_cin = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        do_op(20, 10, 1'b1, 1'b0);
        do_op(1, 0, 1'b1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Dead stage: timeout response, then normal service resumes.
        stage_dead = 1'b1;
        req0_a = 4'd7; req0_b = 4'd6; req0_cin = 1'b1; req0_valid = 1'b1;
        do_op(20, 0, 1'b1, 1'b1);
        stage_dead = 1'b0;
        req1_a = 4'd12; req1_b = 4'd11; req1_cin = 1'b0; req1_valid = 1'b1;
        do_op(1, 0, 1'b1, 1'b0);

        // Reset while waiting for DATA aborts the operation silently.
        stage_dead = 1'b1;
        req1_a = 4'd10; req1_b = 4'd3; req1_cin = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check_val("abort_grant", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("abort_inflight", st_if.st_a, enc4(4'd10));
        @(posedge clk);
        #1;
        reset      = 1'b0;
        req0_valid = 1'b1;
        req0_a = 4'd4; req0_b = 4'd8; req0_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_outputs", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_err}, 0);
        check_val("abort_stage", {st_if.st_ack_in, st_if.st_cin, st_if.st_b, st_if.st_a}, 0);
        stage_dead = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        pref  = 0;
        do_op(3, 0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/arbitro_somador.md
ARBITRO_SOMADOR -- requirements
Module: arbitro_somador

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max clk cycles waited for a DATA or NULL wavefront before error.
REQ-002 Parameter SYNC_STAGES, default 2, meaning flop depth of synchronizers on stage-returned signals (legal 2..3).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  4 each  single-rail operands.
REQ-007 req0_cin, req1_cin  input  1 each  single-rail carry-in.
REQ-008 req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-009 rsp_valid  output  1  result available; rsp_ready  input  1  consumer takes result.
REQ-010 rsp_id  output  1; rsp_sum  output  4; rsp_cout  output  1; rsp_err  output  1  (timeout flag).
REQ-011 st_a, st_b  output  8 each; st_cin  output  2  dual-rail operands to adder stage.
REQ-012 st_ack_in  output  1  acknowledge into stage; st_ack_out  input  1  stage completion; st_soma  input  8  dual-rail sum; st_cout  input  2  dual-rail carry.

Function
REQ-013 Dual-rail pair i = bits [2i+1:2i] = {true,false}; DATA1 = 10, DATA0 = 01, NULL = 00, 11 illegal.
REQ-014 States: IDLE, ISSUE_DATA, WAIT_DATA, ISSUE_NULL, WAIT_NULL, RESPOND.
REQ-015 IDLE: st_* = NULL, st_ack_in = 0; on any req valid with rsp_valid = 0, grant, assert that reqN_ready one cycle, latch operands, -> ISSUE_DATA.
REQ-016 Arbitration round-robin: both valid -> grant requester not granted last; after reset requester 0 has priority.
REQ-017 ISSUE_DATA: drive encoded operands on st_a/st_b/st_cin, -> WAIT_DATA next cycle.
REQ-018 WAIT_DATA: when synchronized st_ack_out = 1 AND all st_soma/st_cout pairs non-NULL and legal for SYNC_STAGES consecutive samples, capture decoded sum/cout, -> ISSUE_NULL.
REQ-019 ISSUE_NULL: drive st_a/st_b/st_cin NULL, set st_ack_in = 1, -> WAIT_NULL.
REQ-020 WAIT_NULL: when synchronized st_ack_out = 0 AND all st_soma/st_cout pairs NULL, clear st_ack_in, -> RESPOND.
REQ-021 RESPOND: rsp_valid = 1 with rsp_id/rsp_sum/rsp_cout/rsp_err stable until rsp_ready = 1 sampled; then -> IDLE; no new grant while rsp_valid = 1.
REQ-022 Cycle counter cleared on entry to WAIT_DATA/WAIT_NULL; reaching TIMEOUT in WAIT_DATA sets err, rsp_sum = 0, rsp_cout = 0, -> ISSUE_NULL; in WAIT_NULL sets err, -> RESPOND.
REQ-023 Illegal pair (11) observed in WAIT_DATA treated as incomplete; only timeout exits.
REQ-024 reqN_ready asserted only in IDLE grant cycle; valid dropping before grant is not an error.
REQ-025 Minimum request-to-rsp_valid latency = 3 + 2*SYNC_STAGES cycles with instant stage.
REQ-026 rsp_sum equals (a + b + cin) mod 16, rsp_cout = carry out of bit 3.

Reset
REQ-027 reset = 0: state IDLE, st_a/st_b/st_cin = NULL, st_ack_in = 0, req*_ready = 0, rsp_valid = 0, rsp_id/rsp_sum/rsp_cout/rsp_err = 0, counter = 0, synchronizers = 0, priority = requester 0.
REQ-028 Reset mid-operation aborts in-flight operation with no response; stage returns to NULL via driven NULL inputs.

Structure
REQ-029 Shared package holds dual-rail codes (DATA0, DATA1, NULL), state encoding, and encode/decode/completion-check functions.
REQ-030 One sub-module: ncl_sincronizador (SYNC_STAGES-deep flop chain, reset to 0) for st_ack_out, st_soma, st_cout.

Verification
REQ-031 Req0 a=3 b=5 cin=0, ideal stage model -> st_a=01011010... rsp_id=0 rsp_sum=8 rsp_cout=0 at minimum latency.
REQ-032 Req1 a=15 b=1 cin=1 -> rsp_sum=1 rsp_cout=1 rsp_err=0.
REQ-033 Both valid continuously from reset -> grants alternate 0,1,0,1 over four operations.
REQ-034 Stage model never raises st_ack_out -> rsp_err=1, rsp_sum=0 at TIMEOUT+~6 cycles, then IDLE.
REQ-035 rsp_ready held 0 for 10 cycles -> outputs stable, req ready stays 0; release -> next grant following cycle.
REQ-036 reset=0 asserted during WAIT_DATA -> next cycle all outputs at reset values, st_* NULL.
